satatrn_rxarb: RTL
==================

// Module: satatrn_rxarb
// PURPOSE
// Receive-side counterpart of the transport TX arbiter. Takes FIS words from
// the link layer, one FIS per packet, and splits them by FIS type. DATA FISs
// (type 8'h46) lose their header word; the payload goes to the data stream.
// Every other FIS type goes whole to the register stream. Oversized FISs are
// truncated, and the remaining words are discarded.
// PARAMETERS
// LGMAXDATA     11    log2 of the maximum DATA payload, in words (2048)
// REG_MAXLEN    7     maximum register FIS length in words, header included
// OPT_LOWPOWER  1'b0  if set, output data/last are zeroed whenever output valid is low
// PORTS
// i_clk         in   1   clock
// i_reset       in   1   asynchronous, active-high reset
// i_valid       in   1   link FIS word valid
// o_ready       out  1   FIS word accepted when i_valid && o_ready
// i_data        in   32  FIS word; FIS type is i_data[7:0] of the first word
// i_last        in   1   last word of the FIS
// o_reg_valid   out  1   register stream valid
// i_reg_ready   in   1   register stream ready
// o_reg_data    out  32  register stream word
// o_reg_last    out  1   register stream last
// o_data_valid  out  1   data stream valid
// i_data_ready  in   1   data stream ready
// o_data_data   out  32  data payload word
// o_data_last   out  1   data payload last
// o_err         out  1   one-cycle pulse: FIS truncated, or DATA FIS had no payload
// BEHAVIOUR
// - Reset (async, i_reset=1): state=IDLE, all valids=0, o_err=0, counters=0.
//   Data/last outputs are reset to 0.
// - Each output is a single register. It loads when (!valid || ready) and an
//   input word is routed to it. Latency is 1 cycle from input accept to output
//   valid. While valid && !ready, the output register holds.
// - IDLE: o_ready = !o_reg_valid || i_reg_ready. On accept:
//   - Type 8'h46 with !i_last: consume the header without output; go to DATA.
//   - Type 8'h46 with i_last: header-only DATA FIS. Drop it, pulse o_err,
//     stay in IDLE.
//   - Any other type: write the word to the reg output; cnt=1.
//     If !i_last, go to REG.
// - REG: o_ready = !o_reg_valid || i_reg_ready. Each accept forwards the word
//   and increments cnt.
//   - The word with cnt==REG_MAXLEN-1 and !i_last is forwarded with
//     o_reg_last forced to 1; pulse o_err; go to DROP.
//   - i_last returns the block to IDLE.
// - DATA: o_ready = !o_data_valid || i_data_ready. Payload words are forwarded
//   with o_data_last=i_last; the counter (LGMAXDATA+1 bits) increments per word.
//   - Payload word number 2**LGMAXDATA with !i_last is forwarded with
//     o_data_last=1; pulse o_err; go to DROP.
//   - i_last returns the block to IDLE.
// - DROP: o_ready=1. Words are discarded. i_last returns the block to IDLE.
// - Once a packet is routed, it stays on that stream until its last word. The
//   two streams never both load in the same cycle. The counter clears on IDLE.
// - Reset mid-packet: output valids clear immediately. The rest of the
//   interrupted FIS is treated as a new FIS; that is the link layer's problem.
// - OPT_LOWPOWER: data/last outputs load 0 whenever the matching valid is
//   cleared.
// TESTING
// - D2H reg FIS, 5 words {..,34h}, sinks always ready -> 5 reg words,
//   reg_last on word 5; data stream idle; o_err=0.
// - DATA FIS: hdr 00000046h + payload 1,2,3,4 -> data stream 1,2,3,4 with
//   last on 4; nothing on the reg stream.
// - Single-word 00000046h with i_last -> no output on either stream;
//   o_err pulses exactly once.
// - LGMAXDATA=2, DATA hdr + 6 payload words -> 4 data words, last on the 4th;
//   o_err=1; words 5-6 dropped with o_ready=1.
// - REG_MAXLEN=7, 9-word reg FIS -> 7 reg words, last forced on 7th; o_err
//   pulse; next FIS routed normally.
// - i_data_ready low for 3 cycles mid-payload -> o_data_* held; o_ready=0;
//   no word lost or duplicated.
// - i_reset asserted mid-DATA -> valids=0 the same cycle; next FIS {..,34h}
//   goes to the reg stream.

Source files
------------

// File: rtl/satatrn_rxarb.sv
// -----------------------------------------------------------------------------
// satatrn_rxarb
// Receive-side transport arbiter. Splits incoming FIS words from the link layer
// into two streams by FIS type (low byte of the first word):
//   - DATA FIS (type 8'h46): header word is consumed, payload goes to the data
//     stream. Payloads longer than 2**LGMAXDATA words are truncated.
//   - any other type: whole FIS goes to the register stream, truncated to
//     REG_MAXLEN words.
// Truncated FISs get a forced "last" on the final forwarded word, and the
// remaining words are swallowed until the link's last word.
//
// Ports
//   i_clk, i_reset               clock, asynchronous active-high reset
//   i_valid/o_ready/i_data/i_last  FIS word input from the link layer
//   o_reg_valid/i_reg_ready/o_reg_data/o_reg_last   register FIS stream
//   o_data_valid/i_data_ready/o_data_data/o_data_last  DATA payload stream
//   o_err                        one-cycle pulse on truncation or empty DATA FIS
// -----------------------------------------------------------------------------
module satatrn_rxarb #(
    parameter int LGMAXDATA    = 11,
    parameter int REG_MAXLEN   = 7,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_data,
    input  logic        i_last,
    output logic        o_reg_valid,
    input  logic        i_reg_ready,
    output logic [31:0] o_reg_data,
    output logic        o_reg_last,
    output logic        o_data_valid,
    input  logic        i_data_ready,
    output logic [31:0] o_data_data,
    output logic        o_data_last,
    output logic        o_err
);

    localparam int CW = LGMAXDATA + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REG  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [7:0] FIS_TYPE_DATA = 8'h46;

    // Counter values seen while the final allowed word is being accepted.
    localparam logic [CW-1:0] REG_TRUNC_CNT  = CW'(REG_MAXLEN - 1);
    localparam logic [CW-1:0] DATA_TRUNC_CNT = CW'((2 ** LGMAXDATA) - 1);
    localparam logic [CW-1:0] CNT_ONE        = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reg_valid_q, reg_valid_d;
    logic [31:0]   reg_data_q, reg_data_d;
    logic          reg_last_q, reg_last_d;
    logic          data_valid_q, data_valid_d;
    logic [31:0]   data_data_q, data_data_d;
    logic          data_last_q, data_last_d;
    logic          err_q, err_d;

    logic          ready_s;
    logic          accept_s;

    // Input ready follows the stream the current packet is bound to.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            S_IDLE,
            S_REG:   ready_s = !reg_valid_q || i_reg_ready;
            S_DATA:  ready_s = !data_valid_q || i_data_ready;
            S_DROP:  ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    assign accept_s = i_valid && ready_s;

    // Next-state, counter, output-register and error-pulse logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        // Retire words taken by the sinks; a load below overrides this.
        if (reg_valid_q && i_reg_ready) begin
            reg_valid_d = 1'b0;
            reg_data_d  = OPT_LOWPOWER ? 32'h0000_0000 : reg_data_q;
            reg_last_d  = OPT_LOWPOWER ? 1'b0 : reg_last_q;
        end else begin
            reg_valid_d = reg_valid_q;
            reg_data_d  = reg_data_q;
            reg_last_d  = reg_last_q;
        end

        if (data_valid_q && i_data_ready) begin
            data_valid_d = 1'b0;
            data_data_d  = OPT_LOWPOWER ? 32'h0000_0000 : data_data_q;
            data_last_d  = OPT_LOWPOWER ? 1'b0 : data_last_q;
        end else begin
            data_valid_d = data_valid_q;
            data_data_d  = data_data_q;
            data_last_d  = data_last_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (accept_s) begin
                    if (i_data[7:0] == FIS_TYPE_DATA) begin
                        // DATA header is never forwarded; a lone header is an error.
                        if (i_last) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        reg_valid_d = 1'b1;
                        reg_data_d  = i_data;
                        reg_last_d  = i_last;
                        cnt_d       = CNT_ONE;
                        state_d     = i_last ? S_IDLE : S_REG;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_REG: begin
                if (accept_s) begin
                    reg_valid_d = 1'b1;
                    reg_data_d  = i_data;
                    cnt_d       = cnt_q + CNT_ONE;
                    if ((cnt_q == REG_TRUNC_CNT) && !i_last) begin
                        reg_last_d = 1'b1;
                        err_d      = 1'b1;
                        state_d    = S_DROP;
                    end else begin
                        reg_last_d = i_last;
                        state_d    = i_last ? S_IDLE : S_REG;
                    end
                end else begin
                    state_d = S_REG;
                end
            end

            S_DATA: begin
                if (accept_s) begin
                    data_valid_d = 1'b1;
                    data_data_d  = i_data;
                    cnt_d        = cnt_q + CNT_ONE;
                    if ((cnt_q == DATA_TRUNC_CNT) && !i_last) begin
                        data_last_d = 1'b1;
                        err_d       = 1'b1;
                        state_d     = S_DROP;
                    end else begin
                        data_last_d = i_last;
                        state_d     = i_last ? S_IDLE : S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end

            S_DROP: begin
                if (accept_s && i_last) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            reg_valid_q  <= 1'b0;
            reg_data_q   <= 32'h0000_0000;
            reg_last_q   <= 1'b0;
            data_valid_q <= 1'b0;
            data_data_q  <= 32'h0000_0000;
            data_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_valid_q  <= reg_valid_d;
            reg_data_q   <= reg_data_d;
            reg_last_q   <= reg_last_d;
            data_valid_q <= data_valid_d;
            data_data_q  <= data_data_d;
            data_last_q  <= data_last_d;
            err_q        <= err_d;
        end
    end

    assign o_ready      = ready_s;
    assign o_reg_valid  = reg_valid_q;
    assign o_reg_data   = reg_data_q;
    assign o_reg_last   = reg_last_q;
    assign o_data_valid = data_valid_q;
    assign o_data_data  = data_data_q;
    assign o_data_last  = data_last_q;
    assign o_err        = err_q;

endmodule
